// File: rtl/slc3_pkg.sv
// Shared SLC-3 datapath/control types: bus width, mux select encodings, sign-extension helper.
// Imported by the datapath, its register file and the control unit.
package slc3_pkg;

  localparam int WIDTH = 16;
  localparam logic [2:0] DR_R7 = 3'b111;

  typedef enum logic [1:0] {
    PC_PLUS1     = 2'b00,
    PC_BUS       = 2'b01,
    PC_ADDR      = 2'b10,
    PC_PLUS1_ALT = 2'b11
  } pcmux_t;

  typedef enum logic [1:0] {
    A2_ZERO  = 2'b00,
    A2_OFF6  = 2'b01,
    A2_OFF9  = 2'b10,
    A2_OFF11 = 2'b11
  } addr2mux_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_AND   = 2'b01,
    ALU_NOT   = 2'b10,
    ALU_PASSA = 2'b11
  } aluk_t;

  // Sign-extend the low n bits of v to WIDTH; n is always a constant at call sites.
  function automatic logic [WIDTH-1:0] sext(input logic [WIDTH-1:0] v, input int n);
    logic signed [WIDTH-1:0] t;
    t = $signed(v << (WIDTH - n));
    return $unsigned(t >>> (WIDTH - n));
  endfunction

endpackage

// File: rtl/slc3_regfile.sv
// SLC-3 8x16 register file: one synchronous write port, two asynchronous read ports.
// Reads in the write cycle return the pre-write value; reset clears all eight registers at once.
module slc3_regfile
  import slc3_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_REG,
  input  logic [2:0]       DR,
  input  logic [WIDTH-1:0] D_in,
  input  logic [2:0]       SR1,
  input  logic [2:0]       SR2,
  output logic [WIDTH-1:0] SR1_out,
  output logic [WIDTH-1:0] SR2_out
);

  logic [WIDTH-1:0] regs [8];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (LD_REG) begin
      regs[DR] <= D_in;
    end
  end

  assign SR1_out = regs[SR1];
  assign SR2_out = regs[SR2];

endmodule

// File: rtl/slc3_datapath.sv
// SLC-3 datapath: PC/MAR/MDR/IR/NZP/BEN/LED registers, shared bus, ALU, address adder, PC mux.
// Every register loads one cycle after its LD strobe from the pre-edge bus; Reset wins over all loads.
module slc3_datapath #(
  parameter int          WIDTH    = 16,
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter logic [2:0]  CC_RESET = 3'b010
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_MAR,
  input  logic             LD_MDR,
  input  logic             LD_IR,
  input  logic             LD_BEN,
  input  logic             LD_CC,
  input  logic             LD_REG,
  input  logic             LD_PC,
  input  logic             LD_LED,
  input  logic             GatePC,
  input  logic             GateMDR,
  input  logic             GateALU,
  input  logic             GateMARMUX,
  input  logic [1:0]       PCMUX,
  input  logic             DRMUX,
  input  logic             SR1MUX,
  input  logic             SR2MUX,
  input  logic             ADDR1MUX,
  input  logic [1:0]       ADDR2MUX,
  input  logic [1:0]       ALUK,
  input  logic             MIO_EN,
  input  logic [WIDTH-1:0] MDR_In,
  output logic [WIDTH-1:0] MAR,
  output logic [WIDTH-1:0] MDR,
  output logic [WIDTH-1:0] IR,
  output logic [WIDTH-1:0] PC,
  output logic [3:0]       Opcode,
  output logic             IR_5,
  output logic             IR_11,
  output logic             BEN,
  output logic [11:0]      LED
);

  import slc3_pkg::pcmux_t;
  import slc3_pkg::PC_PLUS1;
  import slc3_pkg::PC_BUS;
  import slc3_pkg::PC_ADDR;
  import slc3_pkg::PC_PLUS1_ALT;
  import slc3_pkg::addr2mux_t;
  import slc3_pkg::A2_ZERO;
  import slc3_pkg::A2_OFF6;
  import slc3_pkg::A2_OFF9;
  import slc3_pkg::A2_OFF11;
  import slc3_pkg::aluk_t;
  import slc3_pkg::ALU_ADD;
  import slc3_pkg::ALU_AND;
  import slc3_pkg::ALU_NOT;
  import slc3_pkg::ALU_PASSA;
  import slc3_pkg::DR_R7;
  import slc3_pkg::sext;

  logic [WIDTH-1:0] pc_q, mar_q, mdr_q, ir_q;
  logic [2:0]       nzp_q;
  logic             ben_q;
  logic [11:0]      led_q;

  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] sr1_val, sr2_val;
  logic [WIDTH-1:0] alu_b, alu_out;
  logic [WIDTH-1:0] addr1, addr2, addr_sum;
  logic [WIDTH-1:0] pc_plus1, pc_next;
  logic [2:0]       sr1_sel, dr_sel;
  logic [2:0]       nzp_next;
  logic             ben_next;

  assign sr1_sel = SR1MUX ? ir_q[8:6] : ir_q[11:9];
  assign dr_sel  = DRMUX ? DR_R7 : ir_q[11:9];

  slc3_regfile u_regfile (
    .Clk     (Clk),
    .Reset   (Reset),
    .LD_REG  (LD_REG),
    .DR      (dr_sel),
    .D_in    (bus),
    .SR1     (sr1_sel),
    .SR2     (ir_q[2:0]),
    .SR1_out (sr1_val),
    .SR2_out (sr2_val)
  );

  assign alu_b = SR2MUX ? sext(ir_q, 5) : sr2_val;

  always_comb begin
    alu_out = sr1_val;
    case (aluk_t'(ALUK))
      ALU_ADD:   alu_out = sr1_val + alu_b;
      ALU_AND:   alu_out = sr1_val & alu_b;
      ALU_NOT:   alu_out = ~sr1_val;
      ALU_PASSA: alu_out = sr1_val;
    endcase
  end

  assign addr1 = ADDR1MUX ? sr1_val : pc_q;

  always_comb begin
    addr2 = '0;
    case (addr2mux_t'(ADDR2MUX))
      A2_ZERO:  addr2 = '0;
      A2_OFF6:  addr2 = sext(ir_q, 6);
      A2_OFF9:  addr2 = sext(ir_q, 9);
      A2_OFF11: addr2 = sext(ir_q, 11);
    endcase
  end

  assign addr_sum = addr1 + addr2;
  assign pc_plus1 = pc_q + 16'd1;

  // Fixed priority keeps the bus defined even if the controller ever enables two gates.
  always_comb begin
    if (GatePC)          bus = pc_q;
    else if (GateMDR)    bus = mdr_q;
    else if (GateALU)    bus = alu_out;
    else if (GateMARMUX) bus = addr_sum;
    else                 bus = '0;
  end

  always_comb begin
    pc_next = pc_plus1;
    case (pcmux_t'(PCMUX))
      PC_PLUS1:     pc_next = pc_plus1;
      PC_BUS:       pc_next = bus;
      PC_ADDR:      pc_next = addr_sum;
      PC_PLUS1_ALT: pc_next = pc_plus1;
    endcase
  end

  assign nzp_next = {bus[15], (bus == '0), (~bus[15] & (bus != '0))};
  // BEN samples the NZP currently held, so a same-cycle LD_CC cannot affect it.
  assign ben_next = |(ir_q[11:9] & nzp_q);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q  <= PC_RESET;
      mar_q <= '0;
      mdr_q <= '0;
      ir_q  <= '0;
      nzp_q <= CC_RESET;
      ben_q <= 1'b0;
      led_q <= '0;
    end else begin
      if (LD_PC)  pc_q  <= pc_next;
      if (LD_MAR) mar_q <= bus;
      if (LD_MDR) mdr_q <= MIO_EN ? MDR_In : bus;
      if (LD_IR)  ir_q  <= bus;
      if (LD_CC)  nzp_q <= nzp_next;
      if (LD_BEN) ben_q <= ben_next;
      if (LD_LED) led_q <= ir_q[11:0];
    end
  end

  assign PC     = pc_q;
  assign MAR    = mar_q;
  assign MDR    = mdr_q;
  assign IR     = ir_q;
  assign Opcode = ir_q[15:12];
  assign IR_5   = ir_q[5];
  assign IR_11  = ir_q[11];
  assign BEN    = ben_q;
  assign LED    = led_q;

endmodule

// File: tb/tb_slc3_datapath.sv
// Directed self-checking bench for slc3_datapath: fetch, ALU, memory read, branch/JSR, LED and reset.
module tb_slc3_datapath;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic        GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0]  PCMUX, ADDR2MUX, ALUK;
  logic        DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
  logic [15:0] MDR_In;
  logic [15:0] MAR, MDR, IR, PC;
  logic [3:0]  Opcode;
  logic        IR_5, IR_11, BEN;
  logic [11:0] LED;

  int total  = 0;
  int passed = 0;

  slc3_datapath dut (
    .Clk(Clk), .Reset(Reset),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
    .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .MIO_EN(MIO_EN), .MDR_In(MDR_In),
    .MAR(MAR), .MDR(MDR), .IR(IR), .PC(PC), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN), .LED(LED)
  );

  always #5 Clk = ~Clk;

  // The controller must never enable more than one bus driver.
  always @(negedge Clk) begin
    if (!Reset) assert ($countones({GatePC, GateMDR, GateALU, GateMARMUX}) <= 1)
      else $error("multiple bus gates enabled");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} = '0;
    {GatePC, GateMDR, GateALU, GateMARMUX} = '0;
    PCMUX = 2'b00; ADDR2MUX = 2'b00; ALUK = 2'b00;
    DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0; ADDR1MUX = 1'b0;
    MIO_EN = 1'b0; MDR_In = 16'h0000;
  endtask

  task automatic load_mdr(input logic [15:0] v);
    clr(); MIO_EN = 1'b1; MDR_In = v; LD_MDR = 1'b1;
    tick(); clr();
  endtask

  task automatic set_ir(input logic [15:0] v);
    load_mdr(v);
    GateMDR = 1'b1; LD_IR = 1'b1;
    tick(); clr();
  endtask

  task automatic set_pc(input logic [15:0] v);
    load_mdr(v);
    GateMDR = 1'b1; PCMUX = 2'b01; LD_PC = 1'b1;
    tick(); clr();
  endtask

  task automatic test_reset();
    clr(); Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    total++; if (PC !== 16'h0000) $display("FAIL reset_pc got %h want 0000", PC); else passed++;
    total++; if ({MAR, MDR, IR} !== 48'h0) $display("FAIL reset_mar_mdr_ir got %h %h %h want 0", MAR, MDR, IR); else passed++;
    total++; if (dut.nzp_q !== 3'b010) $display("FAIL reset_nzp got %b want 010", dut.nzp_q); else passed++;
    total++; if ({BEN, LED} !== 13'h0) $display("FAIL reset_ben_led got %b %h want 0 000", BEN, LED); else passed++;
  endtask

  task automatic test_fetch();
    set_pc(16'h0005);
    GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; PCMUX = 2'b00;
    tick(); clr();
    total++; if (MAR !== 16'h0005) $display("FAIL fetch_mar got %h want 0005", MAR); else passed++;
    total++; if (PC !== 16'h0006) $display("FAIL fetch_pc got %h want 0006", PC); else passed++;
    set_pc(16'hFFFF);
    GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; PCMUX = 2'b00;
    tick(); clr();
    total++; if (MAR !== 16'hFFFF) $display("FAIL fetch_wrap_mar got %h want FFFF", MAR); else passed++;
    total++; if (PC !== 16'h0000) $display("FAIL fetch_wrap_pc got %h want 0000", PC); else passed++;
    // MDR from the bus when memory is not selected
    GatePC = 1'b1; LD_MDR = 1'b1; MIO_EN = 1'b0;
    tick(); clr();
    total++; if (MDR !== 16'h0000) $display("FAIL mdr_from_bus got %h want 0000", MDR); else passed++;
  endtask

  task automatic test_add_imm();
    set_ir(16'h0400);
    load_mdr(16'h0007);
    GateMDR = 1'b1; LD_REG = 1'b1;
    tick(); clr();
    total++; if (dut.u_regfile.regs[2] !== 16'h0007) $display("FAIL r2_init got %h want 0007", dut.u_regfile.regs[2]); else passed++;
    set_ir(16'h14BD);
    SR1MUX = 1'b1; SR2MUX = 1'b1; ALUK = 2'b00; GateALU = 1'b1;
    LD_REG = 1'b1; LD_CC = 1'b1; LD_BEN = 1'b1;
    #2;
    total++; if (dut.sr1_val !== 16'h0007) $display("FAIL no_bypass_sr1 got %h want 0007", dut.sr1_val); else passed++;
    total++; if (dut.bus !== 16'h0004) $display("FAIL add_bus got %h want 0004", dut.bus); else passed++;
    tick(); clr();
    total++; if (dut.u_regfile.regs[2] !== 16'h0004) $display("FAIL add_r2 got %h want 0004", dut.u_regfile.regs[2]); else passed++;
    total++; if (dut.nzp_q !== 3'b001) $display("FAIL add_nzp got %b want 001", dut.nzp_q); else passed++;
    total++; if (BEN !== 1'b1) $display("FAIL ben_old_nzp got %b want 1", BEN); else passed++;
    set_ir(16'h0E00);
    LD_BEN = 1'b1; tick(); clr();
    total++; if (BEN !== 1'b1) $display("FAIL ben_nzp_mask got %b want 1", BEN); else passed++;
    set_ir(16'h0800);
    LD_BEN = 1'b1; tick(); clr();
    total++; if (BEN !== 1'b0) $display("FAIL ben_n_only got %b want 0", BEN); else passed++;
  endtask

  task automatic test_ldr();
    set_ir(16'h6A00);
    load_mdr(16'h8000);
    total++; if (MDR !== 16'h8000) $display("FAIL ldr_mdr got %h want 8000", MDR); else passed++;
    GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
    tick(); clr();
    total++; if (dut.u_regfile.regs[5] !== 16'h8000) $display("FAIL ldr_r5 got %h want 8000", dut.u_regfile.regs[5]); else passed++;
    total++; if (dut.nzp_q !== 3'b100) $display("FAIL ldr_nzp got %b want 100", dut.nzp_q); else passed++;
  endtask

  task automatic test_alu_not();
    // NOT R3, R5 (R5 = 8000) -> 7FFF, positive
    set_ir(16'h977F);
    SR1MUX = 1'b1; ALUK = 2'b10; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
    tick(); clr();
    total++; if (dut.u_regfile.regs[3] !== 16'h7FFF) $display("FAIL not_r3 got %h want 7FFF", dut.u_regfile.regs[3]); else passed++;
    total++; if (dut.nzp_q !== 3'b001) $display("FAIL not_nzp got %b want 001", dut.nzp_q); else passed++;
    // AND R3, R3, R5 (register operand) -> 0000, zero
    set_ir(16'h56C5);
    SR1MUX = 1'b1; SR2MUX = 1'b0; ALUK = 2'b01; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
    tick(); clr();
    total++; if (dut.u_regfile.regs[3] !== 16'h0000) $display("FAIL and_r3 got %h want 0000", dut.u_regfile.regs[3]); else passed++;
    total++; if (dut.nzp_q !== 3'b010) $display("FAIL and_nzp got %b want 010", dut.nzp_q); else passed++;
  endtask

  task automatic test_branch_led();
    set_pc(16'h0100);
    set_ir(16'h0BFE);
    ADDR2MUX = 2'b10; ADDR1MUX = 1'b0; PCMUX = 2'b10; LD_PC = 1'b1;
    GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1;
    tick(); clr();
    total++; if (PC !== 16'h00FE) $display("FAIL br_pc got %h want 00FE", PC); else passed++;
    total++; if (dut.u_regfile.regs[7] !== 16'h0100) $display("FAIL jsr_r7 got %h want 0100", dut.u_regfile.regs[7]); else passed++;
    GateMARMUX = 1'b1; ADDR2MUX = 2'b10; LD_MAR = 1'b1;
    tick(); clr();
    total++; if (MAR !== 16'h00FC) $display("FAIL marmux got %h want 00FC", MAR); else passed++;
    GatePC = 1'b1; PCMUX = 2'b01; LD_PC = 1'b1;
    tick(); clr();
    total++; if (PC !== 16'h00FE) $display("FAIL pc_self_load got %h want 00FE", PC); else passed++;
    LD_MAR = 1'b1;
    tick(); clr();
    total++; if (MAR !== 16'h0000) $display("FAIL idle_bus got %h want 0000", MAR); else passed++;
    set_ir(16'hD0A5);
    LD_LED = 1'b1;
    tick(); clr();
    total++; if (LED !== 12'h0A5) $display("FAIL led got %h want 0A5", LED); else passed++;
    total++; if ({Opcode, IR_11, IR_5} !== 6'b1101_0_1) $display("FAIL status got %h %b %b want d 0 1", Opcode, IR_11, IR_5); else passed++;
  endtask

  task automatic test_reset_midop();
    set_ir(16'h0E00);
    Reset = 1'b1;
    GatePC = 1'b1; LD_REG = 1'b1; DRMUX = 1'b1; LD_PC = 1'b1; LD_MAR = 1'b1;
    LD_CC = 1'b1; LD_BEN = 1'b1; LD_LED = 1'b1; LD_IR = 1'b1;
    tick(); clr(); Reset = 1'b0;
    total++; if ({PC, MAR, IR} !== 48'h0) $display("FAIL rst_mid_regs got %h %h %h want 0", PC, MAR, IR); else passed++;
    total++; if (dut.u_regfile.regs[7] !== 16'h0000 || dut.u_regfile.regs[5] !== 16'h0000)
      $display("FAIL rst_mid_rf got %h %h want 0 0", dut.u_regfile.regs[7], dut.u_regfile.regs[5]); else passed++;
    total++; if ({dut.nzp_q, BEN, LED} !== {3'b010, 1'b0, 12'h000}) $display("FAIL rst_mid_cc got %b %b %h want 010 0 000", dut.nzp_q, BEN, LED); else passed++;
  endtask

  initial begin
    clr();
    Reset = 1'b1;
    test_reset();
    test_fetch();
    test_add_imm();
    test_ldr();
    test_alu_not();
    test_branch_led();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
